// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the UART frame scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_RD  = 1'b1
  } src_t;

  localparam logic [1:0] FRAME_LEN_ALU = 2'd2;
  localparam logic [1:0] FRAME_LEN_RD  = 2'd1;

endpackage

// File: rtl/tx_req_slot.sv
// One-deep pending result slot with grant-clear/reload and sticky overflow.
module tx_req_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             grant,
  input  logic             ovf_clr,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             ovf
);

  logic take;
  logic drop;

  // A slot being granted this cycle frees up, so it can accept the new pulse.
  assign take = load && (!full || grant);
  assign drop = load && full && !grant;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (take)       full <= 1'b1;
      else if (grant) full <= 1'b0;

      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // NOTE: the payload is not reset; it is only ever consumed while full is set.
  always_ff @(posedge clk) begin
    if (take) data <= din;
  end

endmodule

// File: rtl/tx_frame_sched.sv
// Round-robin scheduler serializing ALU (2-byte) and register-file (1-byte) frames to the UART TX.
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  input  logic [DATA_WIDTH-1:0]   Rd_DATA,
  input  logic                    Rd_DATA_Valid,
  input  logic                    Busy,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    OVF_ALU,
  output logic                    OVF_RD,
  input  logic                    OVF_CLR,
  output logic                    SCHED_BUSY
);

  state_t                  state_q, state_d;
  src_t                    last_grant_q;
  logic [2*DATA_WIDTH-1:0] frame_q;
  logic [1:0]              len_q;
  logic                    idx_q;

  logic                    alu_full, rd_full;
  logic [2*DATA_WIDTH-1:0] alu_data;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    grant_alu, grant_rd;
  logic                    more_bytes;

  tx_req_slot #(.WIDTH(2*DATA_WIDTH)) u_alu_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (ALU_OUT_VALID),
    .din     (ALU_OUT),
    .grant   (grant_alu),
    .ovf_clr (OVF_CLR),
    .full    (alu_full),
    .data    (alu_data),
    .ovf     (OVF_ALU)
  );

  tx_req_slot #(.WIDTH(DATA_WIDTH)) u_rd_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (Rd_DATA_Valid),
    .din     (Rd_DATA),
    .grant   (grant_rd),
    .ovf_clr (OVF_CLR),
    .full    (rd_full),
    .data    (rd_data),
    .ovf     (OVF_RD)
  );

  assign more_bytes = ({1'b0, idx_q} + 2'd1) < len_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    grant_alu = 1'b0;
    grant_rd  = 1'b0;
    case (state_q)
      IDLE: begin
        if (alu_full || rd_full) begin
          state_d = SEND;
          // On a tie the source not served last wins.
          if (alu_full && (!rd_full || last_grant_q == SRC_RD)) grant_alu = 1'b1;
          else                                                 grant_rd  = 1'b1;
        end
      end
      SEND:    if (!Busy) state_d = GAP;
      GAP:     state_d = more_bytes ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_RD;
      idx_q        <= 1'b0;
      len_q        <= FRAME_LEN_RD;
    end else begin
      state_q <= state_d;
      if (grant_alu) begin
        last_grant_q <= SRC_ALU;
        len_q        <= FRAME_LEN_ALU;
        idx_q        <= 1'b0;
      end else if (grant_rd) begin
        last_grant_q <= SRC_RD;
        len_q        <= FRAME_LEN_RD;
        idx_q        <= 1'b0;
      end else if (state_q == GAP && more_bytes) begin
        idx_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_alu)     frame_q <= alu_data;
    else if (grant_rd) frame_q <= {{DATA_WIDTH{1'b0}}, rd_data};
  end

  assign TX_D_VLD   = (state_q == SEND);
  assign TX_P_DATA  = !TX_D_VLD ? '0 :
                      (idx_q ? frame_q[2*DATA_WIDTH-1:DATA_WIDTH] : frame_q[DATA_WIDTH-1:0]);
  assign SCHED_BUSY = alu_full || rd_full || (state_q != IDLE);

endmodule

// File: tb/tb_tx_frame_sched.sv
// Self-checking bench: per-cycle comparison against a queue-based scheduler model plus directed byte-sequence checks.
module tb_tx_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VALID = 1'b0;
  logic [7:0]  Rd_DATA = '0;
  logic        Rd_DATA_Valid = 1'b0;
  logic        Busy = 1'b0;
  logic        OVF_CLR = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        OVF_ALU;
  logic        OVF_RD;
  logic        SCHED_BUSY;

  always #5 clk = ~clk;

  tx_frame_sched #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VALID (ALU_OUT_VALID),
    .Rd_DATA       (Rd_DATA),
    .Rd_DATA_Valid (Rd_DATA_Valid),
    .Busy          (Busy),
    .TX_P_DATA     (TX_P_DATA),
    .TX_D_VLD      (TX_D_VLD),
    .OVF_ALU       (OVF_ALU),
    .OVF_RD        (OVF_RD),
    .OVF_CLR       (OVF_CLR),
    .SCHED_BUSY    (SCHED_BUSY)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending slots, a queue of bytes still to send for the frame in flight,
  // and a phase (0 = nothing in flight, 1 = offering a byte, 2 = post-accept gap).
  bit          started = 1'b0;
  bit          m_alu_full, m_rd_full, m_ovf_alu, m_ovf_rd;
  logic [15:0] m_alu_data;
  logic [7:0]  m_rd_data;
  logic [7:0]  m_bytes[$];
  int          m_phase;
  int          m_last;
  bit          g_alu, g_rd, alu_drop, rd_drop;
  logic [7:0]  dut_sent[$];

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        started    = 1'b1;
        m_alu_full = 1'b0;
        m_rd_full  = 1'b0;
        m_ovf_alu  = 1'b0;
        m_ovf_rd   = 1'b0;
        m_bytes.delete();
        m_phase    = 0;
        m_last     = 1;
      end else begin
        g_alu = 1'b0;
        g_rd  = 1'b0;
        if (m_phase == 0 && (m_alu_full || m_rd_full)) begin
          if (m_alu_full && (!m_rd_full || m_last == 1)) g_alu = 1'b1;
          else                                           g_rd  = 1'b1;
        end
        if (g_alu) begin
          m_bytes = '{m_alu_data[7:0], m_alu_data[15:8]};
          m_phase = 1;
          m_last  = 0;
        end else if (g_rd) begin
          m_bytes = '{m_rd_data};
          m_phase = 1;
          m_last  = 1;
        end else if (m_phase == 1 && !Busy) begin
          void'(m_bytes.pop_front());
          m_phase = 2;
        end else if (m_phase == 2) begin
          m_phase = (m_bytes.size() > 0) ? 1 : 0;
        end

        alu_drop = ALU_OUT_VALID && m_alu_full && !g_alu;
        rd_drop  = Rd_DATA_Valid && m_rd_full && !g_rd;
        if (ALU_OUT_VALID && !alu_drop) begin m_alu_data = ALU_OUT; m_alu_full = 1'b1; end
        else if (g_alu) m_alu_full = 1'b0;
        if (Rd_DATA_Valid && !rd_drop) begin m_rd_data = Rd_DATA; m_rd_full = 1'b1; end
        else if (g_rd) m_rd_full = 1'b0;
        if (alu_drop)     m_ovf_alu = 1'b1;
        else if (OVF_CLR) m_ovf_alu = 1'b0;
        if (rd_drop)      m_ovf_rd = 1'b1;
        else if (OVF_CLR) m_ovf_rd = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("vld", TX_D_VLD, (m_phase == 1));
        check("data", TX_P_DATA, (m_phase == 1) ? m_bytes[0] : 8'h00);
        check("sched_busy", SCHED_BUSY, (m_phase != 0) || m_alu_full || m_rd_full);
        check("ovf_alu", OVF_ALU, m_ovf_alu);
        check("ovf_rd", OVF_RD, m_ovf_rd);
        if (!rst && TX_D_VLD && !Busy) dut_sent.push_back(TX_P_DATA);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic a_en, input logic [15:0] a,
                       input logic r_en, input logic [7:0] r, input logic clr);
    ALU_OUT       = a;
    ALU_OUT_VALID = a_en;
    Rd_DATA       = r;
    Rd_DATA_Valid = r_en;
    OVF_CLR       = clr;
    tick(1);
    ALU_OUT_VALID = 1'b0;
    Rd_DATA_Valid = 1'b0;
    OVF_CLR       = 1'b0;
  endtask

  // Expected bytes packed first-sent in bits [7:0].
  task automatic expect_sent(input string name, input int n, input logic [39:0] exp);
    logic [7:0] b;
    check({name, "_count"}, dut_sent.size(), n);
    for (int i = 0; i < n; i++) begin
      b = exp[i*8 +: 8];
      if (i < dut_sent.size()) check({name, "_byte"}, dut_sent[i], b);
    end
    dut_sent.delete();
  endtask

  initial begin
    tick(2);
    check("rst_vld", TX_D_VLD, 1'b0);
    check("rst_data", TX_P_DATA, 8'h00);
    check("rst_sched_busy", SCHED_BUSY, 1'b0);
    rst = 1'b0;
    tick(1);

    // Single RD byte: valid exactly two edges after the pulse.
    pulse(1'b0, 16'h0, 1'b1, 8'hA5, 1'b0);
    check("rd_t1_vld", TX_D_VLD, 1'b0);
    check("rd_t1_busy", SCHED_BUSY, 1'b1);
    tick(1);
    check("rd_t2_vld", TX_D_VLD, 1'b1);
    check("rd_t2_data", TX_P_DATA, 8'hA5);
    tick(1);
    check("rd_gap_vld", TX_D_VLD, 1'b0);
    tick(4);
    expect_sent("single_rd", 1, 40'hA5);
    check("rd_idle", SCHED_BUSY, 1'b0);

    // Single ALU frame: low byte, gap, high byte.
    pulse(1'b1, 16'h1234, 1'b0, 8'h0, 1'b0);
    tick(1);
    check("alu_b0", TX_P_DATA, 8'h34);
    tick(1);
    check("alu_gap", TX_D_VLD, 1'b0);
    tick(1);
    check("alu_b1", TX_P_DATA, 8'h12);
    tick(8);
    expect_sent("single_alu", 2, 40'h1234);

    // Tie after reset goes to ALU; a fresh ALU pulse during its frame then loses to the waiting RD.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pulse(1'b1, 16'hBEEF, 1'b1, 8'h5A, 1'b0);
    tick(1);
    pulse(1'b1, 16'h1357, 1'b0, 8'h0, 1'b0);
    tick(20);
    expect_sent("rr_seq", 5, 40'h13_57_5A_BE_EF);
    check("rr_no_ovf", OVF_ALU, 1'b0);
    // Last served was ALU, so RD wins this tie.
    pulse(1'b1, 16'hBEEF, 1'b1, 8'h5A, 1'b0);
    tick(15);
    expect_sent("rr_repeat", 3, 40'hBE_EF_5A);

    // Busy holds the first byte stable.
    Busy = 1'b1;
    pulse(1'b1, 16'h1234, 1'b0, 8'h0, 1'b0);
    tick(1);
    check("busy_hold_vld", TX_D_VLD, 1'b1);
    check("busy_hold_data", TX_P_DATA, 8'h34);
    tick(9);
    check("busy_late_data", TX_P_DATA, 8'h34);
    Busy = 1'b0;
    tick(10);
    expect_sent("busy_alu", 2, 40'h1234);

    // RD overflow while the slot is held full, then clear.
    Busy = 1'b1;
    pulse(1'b0, 16'h0, 1'b1, 8'h11, 1'b0);
    tick(1);
    pulse(1'b0, 16'h0, 1'b1, 8'h22, 1'b0);
    pulse(1'b0, 16'h0, 1'b1, 8'h33, 1'b0);
    check("ovf_rd_set", OVF_RD, 1'b1);
    Busy = 1'b0;
    tick(10);
    expect_sent("ovf_rd", 2, 40'h2211);
    check("ovf_rd_sticky", OVF_RD, 1'b1);
    pulse(1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
    check("ovf_rd_clr", OVF_RD, 1'b0);

    // Pulse landing in the grant cycle reloads the slot without overflow.
    pulse(1'b0, 16'h0, 1'b1, 8'h44, 1'b0);
    pulse(1'b0, 16'h0, 1'b1, 8'h55, 1'b0);
    tick(12);
    expect_sent("grant_reload", 2, 40'h5544);
    check("grant_reload_ovf", OVF_RD, 1'b0);

    // Overflow coinciding with clear leaves the flag set.
    Busy = 1'b1;
    pulse(1'b1, 16'h1111, 1'b0, 8'h0, 1'b0);
    tick(1);
    pulse(1'b1, 16'h2222, 1'b0, 8'h0, 1'b0);
    pulse(1'b1, 16'h3333, 1'b0, 8'h0, 1'b0);
    check("ovf_alu_set", OVF_ALU, 1'b1);
    pulse(1'b1, 16'h4444, 1'b0, 8'h0, 1'b1);
    check("ovf_alu_clr_vs_set", OVF_ALU, 1'b1);
    pulse(1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
    check("ovf_alu_clr", OVF_ALU, 1'b0);
    Busy = 1'b0;
    tick(15);
    expect_sent("ovf_alu", 4, 40'h22_22_11_11);

    // Reset between the two ALU bytes discards the frame.
    pulse(1'b1, 16'h1234, 1'b0, 8'h0, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("midrst_vld", TX_D_VLD, 1'b0);
    check("midrst_data", TX_P_DATA, 8'h00);
    check("midrst_busy", SCHED_BUSY, 1'b0);
    rst = 1'b0;
    tick(5);
    expect_sent("midrst", 1, 40'h34);
    pulse(1'b0, 16'h0, 1'b1, 8'h6B, 1'b0);
    tick(8);
    expect_sent("post_rst_rd", 1, 40'h6B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_frame_sched.md
# tx_frame_sched

Frame scheduler that shares the single UART transmitter between two result producers: the ALU, which sends 2-byte results, and the register file, which sends 1-byte read data. Each producer delivers its result as a one-cycle valid pulse into a private one-deep pending slot. A round-robin arbiter picks the next frame and serializes it byte-by-byte to the UART TX under its busy handshake. The block sits between the ALU / register-file outputs and the UART TX parallel input, in the reference-clock domain.

## Interface
- DATA_WIDTH, 8, byte width; ALU result is 2*DATA_WIDTH.
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  reset, synchronous and active-high.
- ALU_OUT  input  2*DATA_WIDTH  ALU result; sampled when ALU_OUT_VALID=1.
- ALU_OUT_VALID  input  1  one-cycle result pulse.
- Rd_DATA  input  DATA_WIDTH  register-file read data; sampled when Rd_DATA_Valid=1.
- Rd_DATA_Valid  input  1  one-cycle read pulse.
- Busy  input  1  UART TX busy; rises no later than 1 cycle after a byte is accepted.
- TX_P_DATA  output  DATA_WIDTH  byte to UART; 0 whenever TX_D_VLD=0.
- TX_D_VLD  output  1  byte valid; held until accepted.
- OVF_ALU  output  1  sticky: ALU pulse dropped.
- OVF_RD  output  1  sticky: read pulse dropped.
- OVF_CLR  input  1  clears both sticky flags.
- SCHED_BUSY  output  1  1 when a slot is pending or a frame is in flight.

## Operation
- Pending slots. A pulse loads the slot: ALU stores 16 bits, RD stores 8 bits. The slot becomes full the next cycle.
  - Pulse while the slot is full and not being granted: data is dropped, the slot is unchanged, and the OVF flag is set.
  - Pulse in the same cycle the slot is granted: the slot reloads with the new data and stays full; no overflow.
- States: IDLE, SEND, GAP.
  - IDLE: if any slot is full, grant it, latch its frame (bytes + length 1 or 2, byte index=0), clear the slot, and go to SEND.
  - Grant rule: if only one slot is full, grant it. If both are full, grant the source not served last.
- SEND: TX_D_VLD=1, TX_P_DATA=frame byte[index] (ALU: index 0 = bits[7:0], index 1 = bits[15:8]).
  - Acceptance is TX_D_VLD=1 and Busy=0 in the same cycle. On acceptance go to GAP.
  - While Busy=1, hold the same byte and stay in SEND.
- GAP: one cycle with TX_D_VLD=0, which protects against double-send before Busy rises.
  - If more bytes remain: increment index and go to SEND.
  - Otherwise go to IDLE.
- Frames are atomic: an ALU frame's two bytes are never interleaved with an RD byte.
- last_grant updates at grant time. Reset value is RD, so ALU wins the first tie.
- OVF_CLR clears the flags. If OVF_CLR and a new overflow occur in the same cycle, the flag ends up set.
- Synchronous rst, including mid-frame:
  - state IDLE, slots empty, frame discarded, last_grant=RD.
  - TX_P_DATA=0, TX_D_VLD=0, OVF_ALU=0, OVF_RD=0, SCHED_BUSY=0 from the cycle after the rst edge.

## Timing
- Outputs TX_D_VLD and TX_P_DATA are registered, decoded from state and frame registers.
- Pulse at cycle t with the block idle: slot full at t+1, grant at t+1, TX_D_VLD=1 at t+2.
- Accept at cycle a:
  - GAP at a+1.
  - Second ALU byte valid at a+2, if Busy=0 then.
  - Next frame valid at a+3 at the earliest.
- Minimum ALU frame: 5 cycles from grant to IDLE with Busy held 0.
- SCHED_BUSY is combinational from slot-full flags and state≠IDLE.

## Structure
- Shared package tx_sched_pkg holds:
  - state enum {IDLE, SEND, GAP};
  - source IDs SRC_ALU=0, SRC_RD=1;
  - frame length constants.
- Sub-module tx_req_slot (parameter WIDTH): one-deep pending register with full flag, grant-clear/reload rule and sticky overflow. Instantiated twice (WIDTH=16, WIDTH=8).
- The top contains the arbiter, FSM, frame register and byte index.

## Test plan
- Single RD: Rd_DATA=0xA5 pulse, Busy=0 -> TX_D_VLD for 1 cycle at t+2 with 0xA5; SCHED_BUSY returns to 0.
- Single ALU: ALU_OUT=0x1234 -> byte 0x34 accepted, one GAP cycle, then 0x12; no further valid.
- Simultaneous pulses after reset (ALU 0xBEEF, RD 0x5A) -> sequence EF, BE, 5A. A repeat of both pulses -> 5A first, then the ALU bytes.
- Busy held 1 for 10 cycles during an ALU frame -> byte 0x34 is held stable with TX_D_VLD=1 throughout; no byte is skipped or duplicated.
- Two RD pulses while the slot is full -> OVF_RD=1, second value never sent. OVF_CLR -> 0. Pulse in the grant cycle -> both values sent, OVF_RD stays 0.
- rst asserted between the two ALU bytes -> next cycle all outputs 0, state IDLE, byte 0x12 never sent. A fresh RD pulse works normally.
